// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, skid buffer for decode stalls, redirect with stale-response discard.
// Latency: the instruction is registered on IF_* the edge after its Imem_ack_i. Zero-wait memory gives one instruction per cycle.
// Backpressure: ID_stall_i freezes the outputs; an ack taken during a stall parks in the skid buffer and requests pause until it drains.
// Optional IF_MISALIGN_CHECK_EN: a misaligned redirect raises a Misaligned_o pulse and halts fetch, instead of silently aligning the target.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ID_stall_i,
    input  logic        ID_PCSrc_i,
    input  logic [31:0] ID_Branch_target_i,
    output logic        Imem_req_o,
    output logic [31:0] Imem_addr_o,
    input  logic        Imem_ack_i,
    input  logic [31:0] Imem_rdata_i,
    output logic [31:0] IF_Instruction_o,
    output logic [31:0] IF_PC_o,
    output logic        IF_valid_o,
    output logic        Misaligned_o
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;              // address of the current/next request
    logic [31:0] redir_pc_q, redir_pc_d;  // target waiting for the stale ack to drain
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;        // fetch halted after a misaligned redirect
    logic        mis_q, mis_d;

    logic        redirect;
    logic        tgt_bad;
    logic [31:0] tgt;
    logic        ack_eff;

    assign redirect = ID_PCSrc_i && !ID_stall_i;

`ifdef IF_MISALIGN_CHECK_EN
    assign tgt_bad = (ID_Branch_target_i[1:0] != 2'b00);
    assign tgt     = ID_Branch_target_i;
`else
    assign tgt_bad = 1'b0;
    assign tgt     = ID_Branch_target_i & ~32'h0000_0003;
`endif

    // Reset gates the request so nothing issued before reset release can be acked.
    assign Imem_req_o  = rst_i && ((state_q == DISCARD) || ((state_q == FETCH) && !fault_q));
    assign Imem_addr_o = pc_q;
    assign ack_eff     = Imem_ack_i && Imem_req_o;

    assign IF_Instruction_o = instr_q;
    assign IF_PC_o          = out_pc_q;
    assign IF_valid_o       = valid_q;
    assign Misaligned_o     = mis_q;

    // Next-state: normal fetch/stall/drain handling first, then redirect overrides everything.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        instr_d      = instr_q;
        out_pc_d     = out_pc_q;
        valid_d      = valid_q;
        fault_d      = fault_q;
        mis_d        = 1'b0;

        case (state_q)
            FETCH: begin
                if (ack_eff) begin
                    pc_d = pc_q + 32'd4;
                    if (ID_stall_i) begin
                        skid_instr_d = Imem_rdata_i;
                        skid_pc_d    = pc_q;
                        state_d      = HOLD;
                    end else begin
                        instr_d  = Imem_rdata_i;
                        out_pc_d = pc_q;
                        valid_d  = 1'b1;
                    end
                end else if (!ID_stall_i) begin
                    valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (!ID_stall_i) begin
                    instr_d  = skid_instr_q;
                    out_pc_d = skid_pc_q;
                    valid_d  = 1'b1;
                    state_d  = FETCH;
                end
            end
            DISCARD: begin
                if (ack_eff) begin
                    pc_d    = redir_pc_q;
                    state_d = FETCH;
                end
                if (!ID_stall_i) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = FETCH;
        endcase

        if (redirect) begin
            valid_d  = 1'b0;
            instr_d  = instr_q;
            out_pc_d = out_pc_q;
            fault_d  = tgt_bad;
            mis_d    = tgt_bad;
            if (!ack_eff && ((state_q == DISCARD) || ((state_q == FETCH) && !fault_q))) begin
                // old request still in flight: keep it on the bus, drop its data later
                redir_pc_d = tgt;
                state_d    = DISCARD;
            end else begin
                pc_d    = tgt;
                state_d = FETCH;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            redir_pc_q   <= RESET_PC;
            skid_instr_q <= NOP;
            skid_pc_q    <= RESET_PC;
            instr_q      <= NOP;
            out_pc_q     <= RESET_PC;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
            mis_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            instr_q      <= instr_d;
            out_pc_q     <= out_pc_d;
            valid_q      <= valid_d;
            fault_q      <= fault_d;
            mis_q        <= mis_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by randomized stall/redirect/latency traffic.
// The reference model is the architectural instruction stream: the next PC decode must see, and the word stored there.
// Memory contents are a fixed function of the address so every delivered word can be checked against its PC.
module tb_if_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ID_stall_i;
    logic        ID_PCSrc_i;
    logic [31:0] ID_Branch_target_i;
    logic        Imem_req_o;
    logic [31:0] Imem_addr_o;
    logic        Imem_ack_i;
    logic [31:0] Imem_rdata_i;
    logic [31:0] IF_Instruction_o;
    logic [31:0] IF_PC_o;
    logic        IF_valid_o;
    logic        Misaligned_o;

    if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .ID_stall_i         (ID_stall_i),
        .ID_PCSrc_i         (ID_PCSrc_i),
        .ID_Branch_target_i (ID_Branch_target_i),
        .Imem_req_o         (Imem_req_o),
        .Imem_addr_o        (Imem_addr_o),
        .Imem_ack_i         (Imem_ack_i),
        .Imem_rdata_i       (Imem_rdata_i),
        .IF_Instruction_o   (IF_Instruction_o),
        .IF_PC_o            (IF_PC_o),
        .IF_valid_o         (IF_valid_o),
        .Misaligned_o       (Misaligned_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] exp_pc   = 32'h0;
    bit          tb_fault = 1'b0;
    int          n_cons   = 0;

    // previous-cycle observations
    bit          have_prev  = 1'b0;
    bit          prev_req, prev_ack, prev_stall, prev_redir;
    logic [31:0] prev_addr, prev_instr, prev_pc;
    logic        prev_valid;

    // random memory latency
    bit          mem_busy = 1'b0;
    int          mem_wait = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h5A5A_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge: drive one cycle of inputs, check against the model, advance to the next falling edge.
    task automatic tick(input bit st, input bit rd, input logic [31:0] tg, input bit ak);
        bit ack_eff;
        ID_stall_i         = st;
        ID_PCSrc_i         = rd;
        ID_Branch_target_i = tg;
        Imem_ack_i         = ak;
        Imem_rdata_i       = ak ? memf(Imem_addr_o) : 32'hBAD0_0BAD;
        ack_eff            = ak && Imem_req_o;

        if (have_prev && prev_req && !prev_ack) begin
            chk("req_held", {31'd0, Imem_req_o}, 32'd1);
            chk("addr_held", Imem_addr_o, prev_addr);
        end
        if (Imem_req_o) chk("addr_aligned", {30'd0, Imem_addr_o[1:0]}, 32'd0);
        if (have_prev && prev_stall) begin
            chk("stall_instr_frozen", IF_Instruction_o, prev_instr);
            chk("stall_pc_frozen", IF_PC_o, prev_pc);
            chk("stall_valid_frozen", {31'd0, IF_valid_o}, {31'd0, prev_valid});
        end
        if (have_prev && prev_redir) chk("valid_after_redirect", {31'd0, IF_valid_o}, 32'd0);
`ifndef IF_MISALIGN_CHECK_EN
        chk("misaligned_tied_low", {31'd0, Misaligned_o}, 32'd0);
`endif

        if (!st && IF_valid_o) begin
            if (tb_fault) begin
                chk("no_delivery_in_fault", {31'd0, IF_valid_o}, 32'd0);
            end else begin
                chk("delivered_pc", IF_PC_o, exp_pc);
                chk("delivered_word", IF_Instruction_o, memf(IF_PC_o));
                exp_pc = exp_pc + 32'd4;
                n_cons++;
            end
        end
        if (!st && rd) begin
            exp_pc = tg & ~32'h3;
`ifdef IF_MISALIGN_CHECK_EN
            tb_fault = (tg[1:0] != 2'b00);
`endif
        end

        have_prev  = 1'b1;
        prev_req   = Imem_req_o;
        prev_ack   = ack_eff;
        prev_addr  = Imem_addr_o;
        prev_stall = st;
        prev_redir = !st && rd;
        prev_instr = IF_Instruction_o;
        prev_pc    = IF_PC_o;
        prev_valid = IF_valid_o;
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0; ID_stall_i = 1'b0; ID_PCSrc_i = 1'b0; ID_Branch_target_i = 32'h0;
        Imem_ack_i = 1'b1; Imem_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk_i); @(negedge clk_i);

        // reset values, with an ack on the bus that must be ignored
        chk("rst_instr", IF_Instruction_o, 32'h0000_0013);
        chk("rst_pc", IF_PC_o, 32'h0);
        chk("rst_valid", {31'd0, IF_valid_o}, 32'd0);
        chk("rst_req", {31'd0, Imem_req_o}, 32'd0);
        chk("rst_mis", {31'd0, Misaligned_o}, 32'd0);
        Imem_ack_i = 1'b0;
        rst_i = 1'b1;
        #1;
        chk("first_req", {31'd0, Imem_req_o}, 32'd1);
        chk("first_addr", Imem_addr_o, 32'h0);

        // zero-latency stream
        tick(0, 0, 0, 1);
        chk("seq_addr_4", Imem_addr_o, 32'h4);
        chk("seq_pc_0", IF_PC_o, 32'h0);
        chk("seq_valid", {31'd0, IF_valid_o}, 32'd1);
        tick(0, 0, 0, 1);
        chk("seq_addr_8", Imem_addr_o, 32'h8);
        chk("seq_pc_4", IF_PC_o, 32'h4);
        tick(0, 0, 0, 1);
        chk("seq_pc_8", IF_PC_o, 32'h8);

        // stall with an ack landing: word goes to the skid buffer, requests stop
        tick(1, 0, 0, 1);
        chk("skid_req_off", {31'd0, Imem_req_o}, 32'd0);
        chk("skid_pc_frozen", IF_PC_o, 32'h8);
        tick(1, 1, 32'h0000_0400, 1);
        chk("skid_req_off2", {31'd0, Imem_req_o}, 32'd0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("skid_drained_pc", IF_PC_o, 32'hC);
        chk("skid_drained_word", IF_Instruction_o, memf(32'hC));
        chk("resume_addr", Imem_addr_o, 32'h10);
        tick(0, 0, 0, 0);
        chk("bubble_valid", {31'd0, IF_valid_o}, 32'd0);

        // redirect with a request outstanding: old request kept until its ack, data dropped
        tick(0, 1, 32'h0000_0100, 0);
        chk("discard_addr_kept", Imem_addr_o, 32'h10);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 1);
        chk("discard_next_addr", Imem_addr_o, 32'h100);
        chk("discard_valid", {31'd0, IF_valid_o}, 32'd0);
        tick(0, 0, 0, 1);
        chk("target_pc", IF_PC_o, 32'h100);

        // redirect coinciding with an ack
        tick(0, 1, 32'h0000_0200, 1);
        chk("same_cycle_addr", Imem_addr_o, 32'h200);
        chk("same_cycle_word_unchanged", IF_Instruction_o, memf(32'h100));
        tick(0, 0, 0, 1);
        chk("same_cycle_target_pc", IF_PC_o, 32'h200);

        // address wrap
        tick(0, 1, 32'hFFFF_FFFC, 0);
        tick(0, 0, 0, 1);
        chk("wrap_addr_top", Imem_addr_o, 32'hFFFF_FFFC);
        tick(0, 0, 0, 1);
        chk("wrap_addr_zero", Imem_addr_o, 32'h0);
        tick(0, 0, 0, 1);
        chk("wrap_pc_zero", IF_PC_o, 32'h0);

        // misaligned redirect
`ifdef IF_MISALIGN_CHECK_EN
        tick(0, 1, 32'h0000_0102, 1);
        chk("mis_pulse", {31'd0, Misaligned_o}, 32'd1);
        chk("mis_no_req", {31'd0, Imem_req_o}, 32'd0);
        tick(0, 0, 0, 0);
        chk("mis_pulse_end", {31'd0, Misaligned_o}, 32'd0);
        chk("mis_still_no_req", {31'd0, Imem_req_o}, 32'd0);
        tick(0, 1, 32'h0000_0300, 0);
        chk("mis_recover_addr", Imem_addr_o, 32'h300);
        tick(0, 0, 0, 1);
        chk("mis_recover_pc", IF_PC_o, 32'h300);
`else
        tick(0, 1, 32'h0000_0102, 1);
        chk("align_addr", Imem_addr_o, 32'h100);
        tick(0, 0, 0, 1);
        chk("align_pc", IF_PC_o, 32'h100);
`endif

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            bit          st, rd, ak;
            logic [31:0] tg;
            if (Imem_req_o) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_wait = $urandom_range(0, 3);
                end
                ak = (mem_wait == 0);
                if (ak) mem_busy = 1'b0;
                else    mem_wait--;
            end else begin
                ak = ($urandom_range(0, 7) == 0);
            end
            st = ($urandom_range(0, 9) < 3);
            rd = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) tg = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           tg = $urandom;
`ifdef IF_MISALIGN_CHECK_EN
            tg = tg & ~32'h3;
`endif
            tick(st, rd, tg, ak);
        end
        chk("progress", {31'd0, (n_cons > 300)}, 32'd1);

        // asynchronous reset between clock edges
        #3 rst_i = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, Imem_req_o}, 32'd0);
        chk("async_rst_valid", {31'd0, IF_valid_o}, 32'd0);
        chk("async_rst_pc", IF_PC_o, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
